// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default opcode width for the ALU responder.
package alu_pkg;

  localparam int OPC_W_DEF = 5;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_MUL = 8;
  localparam int OP_EQ  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, first on the start cycle.
// done rises DATA_W-1 cycles after start and holds until the next start; no backpressure.
module alu_mul_seq #(
  parameter int DATA_W = 2
) (
  input  logic                  fast_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = done_q;
    if (start) begin
      // Bit 0 of b is consumed on the start cycle itself.
      acc_d    = b[0] ? {{DATA_W{1'b0}}, a} : '0;
      mcand_d  = {{DATA_W{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      cnt_d    = CNT_W'(1);
      run_d    = 1'b1;
      done_d   = 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_responder.sv
// Handshaked ALU: single-cycle ops respond 2 cycles after accept; MUL (ALU_RESP_MUL_EN) after DATA_W+2.
// Response held with outputs frozen until rsp_ready; no new request is taken until back in IDLE.
module alu_responder
  import alu_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              fast_clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_status,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rsp_res_q, rsp_res_d;
  logic                rsp_status_q, rsp_status_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   exec_res;
  logic                exec_st;

`ifdef ALU_RESP_MUL_EN
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .a        (a_q),
    .b        (b_q),
    .done     (mul_done),
    .product  (mul_prod)
  );
`endif

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Unlisted opcodes (and MUL when the multiplier is absent) report res=0, status=1.
  always_comb begin
    exec_res = '0;
    exec_st  = 1'b1;
    case (opc_q)
      OPC_W'(OP_ADD): begin exec_res = sum[DATA_W-1:0]; exec_st = sum[DATA_W]; end
      OPC_W'(OP_SUB): begin exec_res = a_q - b_q;       exec_st = (a_q < b_q); end
      OPC_W'(OP_AND): begin exec_res = a_q & b_q;       exec_st = ~|(a_q & b_q); end
      OPC_W'(OP_OR):  begin exec_res = a_q | b_q;       exec_st = ~|(a_q | b_q); end
      OPC_W'(OP_XOR): begin exec_res = a_q ^ b_q;       exec_st = ~|(a_q ^ b_q); end
      OPC_W'(OP_NOT): begin exec_res = ~a_q;            exec_st = ~|(~a_q); end
      OPC_W'(OP_SHL): begin exec_res = a_q << 1;        exec_st = a_q[DATA_W-1]; end
      OPC_W'(OP_SHR): begin exec_res = a_q >> 1;        exec_st = a_q[0]; end
      OPC_W'(OP_EQ):  begin exec_res = '0;              exec_st = (a_q == b_q); end
      default:        begin exec_res = '0;              exec_st = 1'b1; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_res_d    = rsp_res_q;
    rsp_status_d = rsp_status_q;
`ifdef ALU_RESP_MUL_EN
    mul_start    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          opc_d   = req_opcode;
          a_d     = req_a;
          b_d     = req_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_res_d    = exec_res;
        rsp_status_d = exec_st;
        state_d      = ST_RESP;
`ifdef ALU_RESP_MUL_EN
        if (opc_q == OPC_W'(OP_MUL)) begin
          rsp_res_d    = rsp_res_q;
          rsp_status_d = rsp_status_q;
          mul_start    = 1'b1;
          state_d      = ST_MUL;
        end
`endif
      end
      ST_MUL: begin
`ifdef ALU_RESP_MUL_EN
        if (mul_done) begin
          rsp_res_d    = mul_prod[DATA_W-1:0];
          rsp_status_d = |mul_prod[2*DATA_W-1:DATA_W];
          state_d      = ST_RESP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_res_q    <= '0;
      rsp_status_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_res_q    <= rsp_res_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_res    = rsp_res_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_alu_responder.sv
// Randomized self-checking bench for alu_responder against an arithmetic reference model.
module tb_alu_responder;

  localparam int DW = 2;
  localparam int OW = 5;

  logic          fast_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [OW-1:0] req_opcode = '0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_res;
  logic          rsp_status;
  logic          busy;

  int total = 0;
  int bad   = 0;

  alu_responder #(.DATA_W(DW), .OPC_W(OW)) dut (
    .fast_clk   (fast_clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_status (rsp_status),
    .busy       (busy)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int res, output int st, output int lat);
    int mask;
    int p;
    mask = (1 << DW) - 1;
    lat  = 2;
    res  = 0;
    st   = 1;
    case (op)
      0: begin p = a + b; res = p & mask; st = (p > mask) ? 1 : 0; end
      1: begin res = (a - b) & mask; st = (a < b) ? 1 : 0; end
      2: begin res = a & b; st = (res == 0) ? 1 : 0; end
      3: begin res = a | b; st = (res == 0) ? 1 : 0; end
      4: begin res = a ^ b; st = (res == 0) ? 1 : 0; end
      5: begin res = (~a) & mask; st = (res == 0) ? 1 : 0; end
      6: begin res = (a << 1) & mask; st = (a >> (DW - 1)) & 1; end
      7: begin res = a >> 1; st = a & 1; end
`ifdef ALU_RESP_MUL_EN
      8: begin p = a * b; res = p & mask; st = ((p >> DW) != 0) ? 1 : 0; lat = DW + 2; end
`endif
      9: begin res = 0; st = (a == b) ? 1 : 0; end
      default: begin res = 0; st = 1; end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic run_txn(input int op, input int a, input int b, input int stall);
    int res_e, st_e, lat_e, cyc;
    bit ok;
    model(op, a, b, res_e, st_e, lat_e);
    rsp_ready  = (stall == 0);
    req_opcode = OW'(op);
    req_a      = DW'(a);
    req_b      = DW'(b);
    req_valid  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge fast_clk);
    end
    chk("accept", 32'(ok), 1);
    @(posedge fast_clk);
    #1;
    // Scramble inputs and possibly hold a pending request while busy.
    req_opcode = OW'($urandom);
    req_a      = DW'($urandom);
    req_b      = DW'($urandom);
    req_valid  = 1'($urandom_range(0, 1));
    cyc = 0;
    ok  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge fast_clk);
      cyc++;
      if (rsp_valid) begin ok = 1; break; end
      chk("busy_rdy", 32'(req_ready), 0);
      chk("busy_flag", 32'(busy), 1);
    end
    chk("rsp_seen", 32'(ok), 1);
    chk("latency", cyc, lat_e);
    chk("res", 32'(rsp_res), res_e);
    chk("status", 32'(rsp_status), st_e);
    chk("resp_rdy", 32'(req_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge fast_clk);
      chk("hold_vld", 32'(rsp_valid), 1);
      chk("hold_res", 32'(rsp_res), res_e);
      chk("hold_st", 32'(rsp_status), st_e);
      chk("hold_rdy", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge fast_clk);
    chk("post_vld", 32'(rsp_valid), 0);
    chk("post_rdy", 32'(req_ready), 1);
    chk("post_busy", 32'(busy), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int op, a, b, stall;
    bit stale;

    rst_n = 1'b0;
    repeat (2) @(negedge fast_clk);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_res", 32'(rsp_res), 0);
    chk("rst_st", 32'(rsp_status), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge fast_clk);
    chk("rst_rdy", 32'(req_ready), 1);

    run_txn(0, 3, 1, 0);
    run_txn(1, 1, 2, 0);
    run_txn(9, 2, 2, 0);
    run_txn(8, 3, 3, 0);
    run_txn(31, 2, 1, 0);
    run_txn(0, 1, 1, 5);
    run_txn(6, 2, 0, 1);
    run_txn(7, 1, 0, 0);

    for (int n = 0; n < 200; n++) begin
      op    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 31)) : int'($urandom_range(0, 9));
      a     = int'($urandom_range(0, (1 << DW) - 1));
      b     = int'($urandom_range(0, (1 << DW) - 1));
      stall = int'($urandom_range(0, 3));
      run_txn(op, a, b, stall);
    end

    // Reset pulsed while a MUL is in flight.
    req_valid = 1'b0;
    run_txn(0, 3, 3, 0);
    rsp_ready  = 1'b0;
    req_opcode = OW'(8);
    req_a      = DW'(3);
    req_b      = DW'(3);
    req_valid  = 1'b1;
    @(posedge fast_clk);
    #1;
    req_valid = 1'b0;
    @(negedge fast_clk);
    @(negedge fast_clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_res", 32'(rsp_res), 0);
    chk("mid_rst_st", 32'(rsp_status), 0);
    @(negedge fast_clk);
    rst_n = 1'b1;
    @(negedge fast_clk);
    chk("rel_rdy", 32'(req_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fast_clk);
      if (rsp_valid) stale = 1;
    end
    chk("no_stale", 32'(stale), 0);
    run_txn(0, 2, 1, 0);
    req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
